// File: rtl/uart2wb_wb_guard_if.sv
// Bus bundle around the guard: bridge-facing s_* side and system-facing m_* side.
// Signal suffixes are relative to the guard; the master modport is the guard's view.
`timescale 1ns/1ps
interface uart2wb_wb_guard_if;
  logic        s_stb_i;
  logic [31:0] s_adr_i;
  logic        s_we_i;
  logic [31:0] s_dat_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_adr_o;
  logic        m_we_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;

  modport master (
    input  s_stb_i, s_adr_i, s_we_i, s_dat_i, s_sel_i, m_dat_i, m_ack_i, m_err_i,
    output s_dat_o, s_ack_o, m_cyc_o, m_stb_o, m_adr_o, m_we_o, m_dat_o, m_sel_o
  );

  modport slave (
    output s_stb_i, s_adr_i, s_we_i, s_dat_i, s_sel_i, m_dat_i, m_ack_i, m_err_i,
    input  s_dat_o, s_ack_o, m_cyc_o, m_stb_o, m_adr_o, m_we_o, m_dat_o, m_sel_o
  );
endinterface

// File: rtl/uart2wb_wb_guard.sv
// Wishbone master-side guard: registers bridge requests onto the system bus and
// guarantees exactly one upstream ack per request (target ack, error or timeout).
`timescale 1ns/1ps
module uart2wb_wb_guard #(
  parameter int unsigned TO_W     = 10,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 app_clk,
  input  logic                 arst_n,
  input  logic                 cfg_to_enb,
  input  logic [TO_W-1:0]      cfg_to_cyc,
  uart2wb_wb_guard_if.master   bus,
  output logic [7:0]           err_cnt,
  output logic [7:0]           to_cnt,
  output logic [31:0]          last_fault_adr,
  output logic                 fault_pulse
);

  localparam int unsigned CW = TO_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, WAIT_DROP} state_t;

  state_t          state_q, state_d;
  logic            m_stb_q, m_stb_d;
  logic [31:0]     m_adr_q, m_adr_d;
  logic            m_we_q, m_we_d;
  logic [31:0]     m_dat_q, m_dat_d;
  logic [3:0]      m_sel_q, m_sel_d;
  logic [31:0]     s_dat_q, s_dat_d;
  logic            s_ack_q, s_ack_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      to_cnt_q, to_cnt_d;
  logic [31:0]     fault_adr_q, fault_adr_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   to_lim;
  logic [CW-1:0]   to_nxt;

  // Timeout limit (0 behaves as 1) and the counter value after this cycle's tick
  always_comb begin
    to_lim = (cfg_to_cyc == '0) ? CW'(1) : CW'(cfg_to_cyc);
    to_nxt = CW'(to_q) + CW'(1);
  end

  // Next-state and datapath: accept, wait for err/ack/timeout, ack once, wait for strobe drop
  always_comb begin
    state_d     = state_q;
    m_stb_d     = m_stb_q;
    m_adr_d     = m_adr_q;
    m_we_d      = m_we_q;
    m_dat_d     = m_dat_q;
    m_sel_d     = m_sel_q;
    s_dat_d     = s_dat_q;
    s_ack_d     = 1'b0;
    to_d        = to_q;
    err_cnt_d   = err_cnt_q;
    to_cnt_d    = to_cnt_q;
    fault_adr_d = fault_adr_q;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_stb_i) begin
          m_adr_d = bus.s_adr_i;
          m_we_d  = bus.s_we_i;
          m_dat_d = bus.s_dat_i;
          m_sel_d = bus.s_sel_i;
          to_d    = '0;
          m_stb_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cfg_to_enb) begin
          to_d = TO_W'(to_nxt);
        end
        if (bus.m_err_i) begin
          s_dat_d     = ERR_DATA;
          err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          fault_adr_d = m_adr_q;
          fault_d     = 1'b1;
          s_ack_d     = 1'b1;
          m_stb_d     = 1'b0;
          state_d     = RESP;
        end else if (bus.m_ack_i) begin
          if (!m_we_q) begin
            s_dat_d = bus.m_dat_i;
          end
          s_ack_d = 1'b1;
          m_stb_d = 1'b0;
          state_d = RESP;
        end else if (cfg_to_enb && (to_nxt >= to_lim)) begin
          s_dat_d     = ERR_DATA;
          to_cnt_d    = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
          fault_adr_d = m_adr_q;
          fault_d     = 1'b1;
          s_ack_d     = 1'b1;
          m_stb_d     = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!bus.s_stb_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        m_stb_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight transaction
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      m_stb_q     <= 1'b0;
      m_adr_q     <= '0;
      m_we_q      <= 1'b0;
      m_dat_q     <= '0;
      m_sel_q     <= '0;
      s_dat_q     <= '0;
      s_ack_q     <= 1'b0;
      to_q        <= '0;
      err_cnt_q   <= '0;
      to_cnt_q    <= '0;
      fault_adr_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_stb_q     <= m_stb_d;
      m_adr_q     <= m_adr_d;
      m_we_q      <= m_we_d;
      m_dat_q     <= m_dat_d;
      m_sel_q     <= m_sel_d;
      s_dat_q     <= s_dat_d;
      s_ack_q     <= s_ack_d;
      to_q        <= to_d;
      err_cnt_q   <= err_cnt_d;
      to_cnt_q    <= to_cnt_d;
      fault_adr_q <= fault_adr_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.m_cyc_o    = m_stb_q;
  assign bus.m_stb_o    = m_stb_q;
  assign bus.m_adr_o    = m_adr_q;
  assign bus.m_we_o     = m_we_q;
  assign bus.m_dat_o    = m_dat_q;
  assign bus.m_sel_o    = m_sel_q;
  assign bus.s_dat_o    = s_dat_q;
  assign bus.s_ack_o    = s_ack_q;
  assign err_cnt        = err_cnt_q;
  assign to_cnt         = to_cnt_q;
  assign last_fault_adr = fault_adr_q;
  assign fault_pulse    = fault_q;

endmodule

// File: tb/tb_uart2wb_wb_guard.sv
// Self-checking bench for uart2wb_wb_guard: expected responses are queued when a
// request is issued and popped when the guard acks upstream.
`timescale 1ns/1ps
module tb_uart2wb_wb_guard;
  localparam int unsigned TO_W = 10;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  logic            app_clk = 1'b0;
  logic            arst_n  = 1'b0;
  logic            cfg_to_enb = 1'b0;
  logic [TO_W-1:0] cfg_to_cyc = '0;
  logic [7:0]      err_cnt, to_cnt;
  logic [31:0]     last_fault_adr;
  logic            fault_pulse;

  uart2wb_wb_guard_if bus ();

  uart2wb_wb_guard #(.TO_W(TO_W), .ERR_DATA(ERR)) dut (
    .app_clk        (app_clk),
    .arst_n         (arst_n),
    .cfg_to_enb     (cfg_to_enb),
    .cfg_to_cyc     (cfg_to_cyc),
    .bus            (bus),
    .err_cnt        (err_cnt),
    .to_cnt         (to_cnt),
    .last_fault_adr (last_fault_adr),
    .fault_pulse    (fault_pulse)
  );

  always #5 app_clk = ~app_clk;

  typedef struct { logic [31:0] dat; logic fault; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] m_err_cnt = 8'd0;
  logic [7:0] m_to_cnt  = 8'd0;

  task automatic cyc();
    @(posedge app_clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    bus.s_stb_i = 1'b1;
    bus.s_we_i  = we;
    bus.s_adr_i = adr;
    bus.s_dat_i = dat;
    bus.s_sel_i = sel;
    cyc();
  endtask

  task automatic end_req();
    bus.s_stb_i = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic wait_ack(input int budget, output int stb_cyc, output bit got);
    stb_cyc = 0;
    got     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.s_ack_o) begin
        got = 1'b1;
        break;
      end
      if (bus.m_stb_o) stb_cyc++;
      cyc();
    end
  endtask

  task automatic test_reset();
    cyc();
    n_checks++; if ({bus.s_ack_o, bus.m_stb_o, bus.m_cyc_o, fault_pulse} !== 4'b0) begin
      n_errors++; $display("FAIL reset_ctl: got %b expected 0000", {bus.s_ack_o, bus.m_stb_o, bus.m_cyc_o, fault_pulse}); end
    n_checks++; if ({bus.m_adr_o, bus.s_dat_o, last_fault_adr} !== 96'h0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0", {bus.m_adr_o, bus.s_dat_o, last_fault_adr}); end
    n_checks++; if ({err_cnt, to_cnt} !== 16'h0) begin
      n_errors++; $display("FAIL reset_cnt: got %h expected 0", {err_cnt, to_cnt}); end
    arst_n = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    exp_q.push_back('{dat: 32'h1234_5678, fault: 1'b0});
    start_req(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    n_checks++; if ({bus.m_stb_o, bus.m_cyc_o} !== 2'b11) begin
      n_errors++; $display("FAIL read_stb: got %b expected 11", {bus.m_stb_o, bus.m_cyc_o}); end
    n_checks++; if (bus.m_adr_o !== 32'h3000_0010) begin
      n_errors++; $display("FAIL read_adr: got %h expected 30000010", bus.m_adr_o); end
    cyc();
    bus.m_ack_i = 1'b1; bus.m_dat_i = 32'h1234_5678;
    cyc();
    bus.m_ack_i = 1'b0; bus.m_dat_i = 32'h0;
    n_checks++; if ({bus.s_ack_o, bus.m_stb_o} !== 2'b10) begin
      n_errors++; $display("FAIL read_ack: got %b expected 10", {bus.s_ack_o, bus.m_stb_o}); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.s_dat_o, fault_pulse} !== {e.dat, e.fault}) begin
      n_errors++; $display("FAIL read_resp: got %h/%b expected %h/%b", bus.s_dat_o, fault_pulse, e.dat, e.fault); end
    n_checks++; if ({err_cnt, to_cnt} !== {m_err_cnt, m_to_cnt}) begin
      n_errors++; $display("FAIL read_cnt: got %h expected %h", {err_cnt, to_cnt}, {m_err_cnt, m_to_cnt}); end
    end_req();
  endtask

  task automatic test_write();
    exp_q.push_back('{dat: 32'h1234_5678, fault: 1'b0});
    start_req(1'b1, 32'h3000_0020, 32'hA5A5_0001, 4'b0011);
    n_checks++; if ({bus.m_we_o, bus.m_dat_o, bus.m_sel_o} !== {1'b1, 32'hA5A5_0001, 4'b0011}) begin
      n_errors++; $display("FAIL write_bus: got %b/%h/%b expected 1/a5a50001/0011", bus.m_we_o, bus.m_dat_o, bus.m_sel_o); end
    bus.m_ack_i = 1'b1; bus.m_dat_i = 32'hFFFF_0000;
    cyc();
    bus.m_ack_i = 1'b0; bus.m_dat_i = 32'h0;
    e = exp_q.pop_front();
    n_checks++; if ({bus.s_ack_o, bus.s_dat_o, fault_pulse} !== {1'b1, e.dat, e.fault}) begin
      n_errors++; $display("FAIL write_resp: got %b/%h/%b expected 1/%h/%b", bus.s_ack_o, bus.s_dat_o, fault_pulse, e.dat, e.fault); end
    bus.s_stb_i = 1'b0;
    cyc();
    n_checks++; if (bus.s_ack_o !== 1'b0) begin
      n_errors++; $display("FAIL write_ack_width: got %b expected 0", bus.s_ack_o); end
    cyc();
  endtask

  task automatic test_timeout();
    int  sc;
    bit  got;
    cfg_to_enb = 1'b1;
    cfg_to_cyc = TO_W'(5);
    exp_q.push_back('{dat: ERR, fault: 1'b1});
    start_req(1'b0, 32'h4000_0004, 32'h0, 4'hF);
    wait_ack(20, sc, got);
    n_checks++; if (!got) begin
      n_errors++; $display("FAIL timeout_ack: got no ack expected ack within 20 cycles"); end
    n_checks++; if (sc !== 5) begin
      n_errors++; $display("FAIL timeout_stb_len: got %0d expected 5", sc); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.s_dat_o, fault_pulse} !== {e.dat, e.fault}) begin
      n_errors++; $display("FAIL timeout_resp: got %h/%b expected %h/%b", bus.s_dat_o, fault_pulse, e.dat, e.fault); end
    m_to_cnt = m_to_cnt + 8'd1;
    n_checks++; if ({to_cnt, err_cnt, last_fault_adr} !== {m_to_cnt, m_err_cnt, 32'h4000_0004}) begin
      n_errors++; $display("FAIL timeout_stat: got %h/%h/%h expected %h/%h/40000004", to_cnt, err_cnt, last_fault_adr, m_to_cnt, m_err_cnt); end
    end_req();
  endtask

  task automatic test_err_ack();
    exp_q.push_back('{dat: ERR, fault: 1'b1});
    start_req(1'b0, 32'h6000_0008, 32'h0, 4'hF);
    bus.m_ack_i = 1'b1; bus.m_err_i = 1'b1; bus.m_dat_i = 32'h1111_2222;
    cyc();
    bus.m_ack_i = 1'b0; bus.m_err_i = 1'b0; bus.m_dat_i = 32'h0;
    e = exp_q.pop_front();
    n_checks++; if ({bus.s_ack_o, bus.s_dat_o, fault_pulse} !== {1'b1, e.dat, e.fault}) begin
      n_errors++; $display("FAIL err_resp: got %b/%h/%b expected 1/%h/%b", bus.s_ack_o, bus.s_dat_o, fault_pulse, e.dat, e.fault); end
    m_err_cnt = m_err_cnt + 8'd1;
    n_checks++; if ({err_cnt, to_cnt, last_fault_adr} !== {m_err_cnt, m_to_cnt, 32'h6000_0008}) begin
      n_errors++; $display("FAIL err_stat: got %h/%h/%h expected %h/%h/60000008", err_cnt, to_cnt, last_fault_adr, m_err_cnt, m_to_cnt); end
    end_req();
    n_checks++; if (fault_pulse !== 1'b0) begin
      n_errors++; $display("FAIL err_pulse_width: got %b expected 0", fault_pulse); end
    cfg_to_enb = 1'b0;
  endtask

  task automatic test_held_strobe();
    int extra;
    exp_q.push_back('{dat: 32'h0BAD_F00D, fault: 1'b0});
    start_req(1'b0, 32'h7000_0000, 32'h0, 4'hF);
    bus.m_ack_i = 1'b1; bus.m_dat_i = 32'h0BAD_F00D;
    cyc();
    bus.m_ack_i = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if ({bus.s_ack_o, bus.s_dat_o} !== {1'b1, e.dat}) begin
      n_errors++; $display("FAIL held_first: got %b/%h expected 1/%h", bus.s_ack_o, bus.s_dat_o, e.dat); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.m_stb_o || bus.s_ack_o) extra++;
    end
    n_checks++; if (extra !== 0) begin
      n_errors++; $display("FAIL held_no_reaccept: got %0d active cycles expected 0", extra); end
    bus.s_stb_i = 1'b0;
    cyc();
    exp_q.push_back('{dat: 32'h0000_00C3, fault: 1'b0});
    start_req(1'b0, 32'h7000_0004, 32'h0, 4'hF);
    n_checks++; if ({bus.m_stb_o, bus.m_adr_o} !== {1'b1, 32'h7000_0004}) begin
      n_errors++; $display("FAIL held_second: got %b/%h expected 1/70000004", bus.m_stb_o, bus.m_adr_o); end
    bus.m_ack_i = 1'b1; bus.m_dat_i = 32'h0000_00C3;
    cyc();
    bus.m_ack_i = 1'b0; bus.m_dat_i = 32'h0;
    e = exp_q.pop_front();
    n_checks++; if ({bus.s_ack_o, bus.s_dat_o} !== {1'b1, e.dat}) begin
      n_errors++; $display("FAIL held_second_resp: got %b/%h expected 1/%h", bus.s_ack_o, bus.s_dat_o, e.dat); end
    end_req();
  endtask

  task automatic test_reset_mid_req();
    int acks;
    cfg_to_enb = 1'b0;
    start_req(1'b1, 32'h8000_0010, 32'h5555_AAAA, 4'hF);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_ack_o) acks++;
      cyc();
    end
    n_checks++; if ({acks != 0, bus.m_stb_o} !== 2'b01) begin
      n_errors++; $display("FAIL no_to_wait: got acks=%0d stb=%b expected 0/1", acks, bus.m_stb_o); end
    arst_n = 1'b0;
    #1;
    m_err_cnt = 8'd0;
    m_to_cnt  = 8'd0;
    n_checks++; if ({bus.m_stb_o, bus.m_cyc_o, bus.s_ack_o, fault_pulse, bus.m_adr_o, bus.m_dat_o, bus.s_dat_o} !== '0) begin
      n_errors++; $display("FAIL rst_mid_out: got %b/%h/%h/%h expected all 0", {bus.m_stb_o, bus.m_cyc_o, bus.s_ack_o, fault_pulse}, bus.m_adr_o, bus.m_dat_o, bus.s_dat_o); end
    n_checks++; if ({err_cnt, to_cnt, last_fault_adr} !== {m_err_cnt, m_to_cnt, 32'h0}) begin
      n_errors++; $display("FAIL rst_mid_stat: got %h/%h/%h expected 0", err_cnt, to_cnt, last_fault_adr); end
    bus.s_stb_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.s_ack_o) acks++;
    end
    arst_n = 1'b1;
    cyc();
    if (bus.s_ack_o) acks++;
    n_checks++; if (acks !== 0) begin
      n_errors++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks); end
  endtask

  task automatic test_saturation();
    int sc;
    bit got;
    cfg_to_enb = 1'b1;
    cfg_to_cyc = '0;
    for (int k = 1; k <= 260; k++) begin
      exp_q.push_back('{dat: ERR, fault: 1'b1});
      start_req(1'b0, 32'h9000_0000 + 32'(k * 4), 32'h0, 4'hF);
      wait_ack(10, sc, got);
      n_checks++; if (!got) begin
        n_errors++; $display("FAIL sat_ack_%0d: got no ack expected ack", k); end
      if (k == 1) begin
        n_checks++; if (sc !== 1) begin
          n_errors++; $display("FAIL sat_zero_limit: got %0d stb cycles expected 1", sc); end
      end
      e = exp_q.pop_front();
      n_checks++; if ({bus.s_dat_o, fault_pulse} !== {e.dat, e.fault}) begin
        n_errors++; $display("FAIL sat_resp_%0d: got %h/%b expected %h/%b", k, bus.s_dat_o, fault_pulse, e.dat, e.fault); end
      if (m_to_cnt != 8'hFF) m_to_cnt = m_to_cnt + 8'd1;
      n_checks++; if ({to_cnt, err_cnt} !== {m_to_cnt, m_err_cnt}) begin
        n_errors++; $display("FAIL sat_cnt_%0d: got %h/%h expected %h/%h", k, to_cnt, err_cnt, m_to_cnt, m_err_cnt); end
      end_req();
    end
    n_checks++; if ({to_cnt, last_fault_adr} !== {8'hFF, 32'h9000_0000 + 32'(260 * 4)}) begin
      n_errors++; $display("FAIL sat_final: got %h/%h expected ff/%h", to_cnt, last_fault_adr, 32'h9000_0000 + 32'(260 * 4)); end
  endtask

  initial begin
    bus.s_stb_i = 1'b0;
    bus.s_adr_i = '0;
    bus.s_we_i  = 1'b0;
    bus.s_dat_i = '0;
    bus.s_sel_i = '0;
    bus.m_dat_i = '0;
    bus.m_ack_i = 1'b0;
    bus.m_err_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_err_ack();
    test_held_strobe();
    test_reset_mid_req();
    test_saturation();
    n_checks++; if (exp_q.size() !== 0) begin
      n_errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
